// File: rtl/alarm_time_setter_pkg.sv
// Shared types and BCD helpers for the alarm/time entry controller.
// Holds the edit FSM encoding, display field codes and wrap-around digit arithmetic.
package alarm_time_setter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EDIT_HR  = 2'd1,
        ST_EDIT_MIN = 2'd2,
        ST_COMMIT   = 2'd3
    } state_t;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HR   = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;

    localparam logic [1:0] HR_TENS_MAX   = 2'd2;  // hours top out at 23
    localparam logic [3:0] HR_UNITS_MAX  = 4'd3;
    localparam logic [3:0] MIN_TENS_MAX  = 4'd5;  // minutes top out at 59
    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

    typedef struct packed {
        logic [1:0] hr_1;
        logic [3:0] hr_0;
        logic [3:0] min_1;
        logic [3:0] min_0;
    } bcd_time_t;

    function automatic bcd_time_t inc_hours(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.hr_1 == HR_TENS_MAX && t.hr_0 == HR_UNITS_MAX) begin
            r.hr_1 = 2'd0;
            r.hr_0 = 4'd0;
        end else if (t.hr_0 == BCD_DIGIT_MAX) begin
            r.hr_1 = t.hr_1 + 2'd1;
            r.hr_0 = 4'd0;
        end else begin
            r.hr_0 = t.hr_0 + 4'd1;
        end
        return r;
    endfunction

    function automatic bcd_time_t inc_minutes(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.min_0 != BCD_DIGIT_MAX) begin
            r.min_0 = t.min_0 + 4'd1;
        end else begin
            r.min_0 = 4'd0;
            r.min_1 = (t.min_1 == MIN_TENS_MAX) ? 4'd0 : t.min_1 + 4'd1;
        end
        return r;
    endfunction

    // Each field is checked independently so a bad hour does not discard good minutes.
    function automatic bcd_time_t clamp_time(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (!((t.hr_1 < HR_TENS_MAX && t.hr_0 <= BCD_DIGIT_MAX) ||
              (t.hr_1 == HR_TENS_MAX && t.hr_0 <= HR_UNITS_MAX))) begin
            r.hr_1 = 2'd0;
            r.hr_0 = 4'd0;
        end
        if (!(t.min_1 <= MIN_TENS_MAX && t.min_0 <= BCD_DIGIT_MAX)) begin
            r.min_1 = 4'd0;
            r.min_0 = 4'd0;
        end
        return r;
    endfunction

endpackage

// File: rtl/alarm_time_setter_btn_debounce.sv
// Two-flop synchroniser plus stable-level filter for one raw front-panel button.
// Emits a single-cycle press pulse when a new high level is accepted; releases are silent.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 2
) (
    input  logic clk,
    input  logic areset,
    input  logic raw,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_1;
    logic             sync_2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2 != level) begin
                if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync_2;
                    cnt   <= '0;
                    press <= sync_2;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/alarm_time_setter.sv
// Button-driven time/alarm entry controller for the alarm clock core.
// Edits hours then minutes in BCD and holds the load strobe long enough for the 1 s domain.
module alarm_time_setter
    import alarm_time_setter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int LD_HOLD_CYCLES  = 12,
    parameter int TIMEOUT_CYCLES  = 300
) (
    input  logic       clk,
    input  logic       areset,
    input  logic       btn_time,
    input  logic       btn_alarm,
    input  logic       btn_up,
    input  logic       btn_next,
    input  logic [1:0] cur_hr_1,
    input  logic [3:0] cur_hr_0,
    input  logic [3:0] cur_min_1,
    input  logic [3:0] cur_min_0,
    output logic [1:0] hr_in_1,
    output logic [3:0] hr_in_0,
    output logic [3:0] min_in_1,
    output logic [3:0] min_in_0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic [1:0] edit_field,
    output logic       edit_alarm
);

    localparam int HOLD_W = $clog2(LD_HOLD_CYCLES);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES);

    logic time_ev, alarm_ev, up_ev, next_ev;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_time  (.clk(clk), .areset(areset), .raw(btn_time),  .press(time_ev));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_alarm (.clk(clk), .areset(areset), .raw(btn_alarm), .press(alarm_ev));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up    (.clk(clk), .areset(areset), .raw(btn_up),    .press(up_ev));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next  (.clk(clk), .areset(areset), .raw(btn_next),  .press(next_ev));

    state_t            state, state_next;
    logic              alarm_sel, alarm_sel_next;
    bcd_time_t         digits, digits_next;
    bcd_time_t         shadow, shadow_next;
    logic [TO_W-1:0]   idle_cnt, idle_cnt_next;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state     <= ST_IDLE;
            alarm_sel <= 1'b0;
            digits    <= '0;
            shadow    <= '0;
            idle_cnt  <= '0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_next;
            alarm_sel <= alarm_sel_next;
            digits    <= digits_next;
            shadow    <= shadow_next;
            idle_cnt  <= idle_cnt_next;
            hold_cnt  <= hold_cnt_next;
        end
    end

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        state_next     = state;
        alarm_sel_next = alarm_sel;
        digits_next    = digits;
        shadow_next    = shadow;
        idle_cnt_next  = idle_cnt;
        hold_cnt_next  = hold_cnt;
        case (state)
            ST_IDLE: begin
                if (time_ev) begin
                    state_next     = ST_EDIT_HR;
                    alarm_sel_next = 1'b0;
                    digits_next    = clamp_time({cur_hr_1, cur_hr_0, cur_min_1, cur_min_0});
                    idle_cnt_next  = '0;
                end else if (alarm_ev) begin
                    state_next     = ST_EDIT_HR;
                    alarm_sel_next = 1'b1;
                    digits_next    = shadow;
                    idle_cnt_next  = '0;
                end
            end
            ST_EDIT_HR, ST_EDIT_MIN: begin
                // next outranks up when both arrive in the same cycle
                if (next_ev) begin
                    idle_cnt_next = '0;
                    if (state == ST_EDIT_HR) begin
                        state_next = ST_EDIT_MIN;
                    end else begin
                        state_next    = ST_COMMIT;
                        hold_cnt_next = '0;
                        if (alarm_sel) shadow_next = digits;
                    end
                end else if (up_ev) begin
                    idle_cnt_next = '0;
                    digits_next   = (state == ST_EDIT_HR) ? inc_hours(digits) : inc_minutes(digits);
                end else if (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_next    = ST_IDLE;
                    idle_cnt_next = '0;
                end else begin
                    idle_cnt_next = idle_cnt + TO_W'(1);
                end
            end
            ST_COMMIT: begin
                if (hold_cnt == HOLD_W'(LD_HOLD_CYCLES - 1)) begin
                    state_next    = ST_IDLE;
                    hold_cnt_next = '0;
                end else begin
                    hold_cnt_next = hold_cnt + HOLD_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        edit_field = FIELD_NONE;
        case (state)
            ST_EDIT_HR:  edit_field = FIELD_HR;
            ST_EDIT_MIN: edit_field = FIELD_MIN;
            default:     edit_field = FIELD_NONE;
        endcase
    end

    // Strobes decode straight from registers so areset clears them without waiting for an edge.
    assign LD_time    = (state == ST_COMMIT) && !alarm_sel;
    assign LD_alarm   = (state == ST_COMMIT) &&  alarm_sel;
    assign edit_alarm = alarm_sel;
    assign hr_in_1    = digits.hr_1;
    assign hr_in_0    = digits.hr_0;
    assign min_in_1   = digits.min_1;
    assign min_in_0   = digits.min_0;

endmodule
